stream_sum_avg: RTL

- Sequential successor to the team's combinational six-input sum/average block.
- Accepts one DATA_W-bit sample per cycle over a valid/ready handshake and accumulates a frame of up to NUM_SAMPLES samples.
- At frame end, emits the frame sum, the shifted average and the sample count over a valid/ready output.
- Sits between a sample producer and downstream statistics logic.

---
 rtl/stream_sum_avg.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/stream_sum_avg.sv
// Purpose : accumulates a frame of unsigned samples and reports its sum, shifted average and count.
// Latency : result is registered on the edge that accepts the frame-end sample (visible next cycle).
// Backpr. : in_ready drops while a result is held; the result stays stable until out_ready.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   clr                 synchronous frame abort; drops any partial frame and any held result
//   in_valid/in_ready   sample handshake; in_data is the sample, in_last ends a short frame
//   out_valid/out_ready result handshake; sum_out, avg_out, cnt_out describe the finished frame
module stream_sum_avg #(
  parameter int DATA_W      = 8,
  parameter int NUM_SAMPLES = 6,
  parameter int AVG_SHIFT   = 2,
  parameter int ROUND       = 0,
  parameter int SUM_W       = DATA_W + $clog2(NUM_SAMPLES),
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [SUM_W-1:0]  avg_out,
  output logic [CNT_W-1:0]  cnt_out
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Counter value of the sample that completes a full frame.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  // Half an LSB of the average, added before the shift when rounding half up.
  localparam logic [SUM_W:0] RND_ADD =
    (SUM_W + 1)'((ROUND != 0) ? (1 << (AVG_SHIFT - 1)) : 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SUM_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [SUM_W-1:0]   r_sum;
  logic [SUM_W-1:0]   r_avg;
  logic [CNT_W-1:0]   r_cnt_out;

  logic               w_accept;
  logic               w_cnt_full;
  logic               w_frame_end;
  logic               w_out_hs;
  logic [SUM_W-1:0]   w_sum_nxt;
  logic [SUM_W:0]     w_rnd_sum;
  logic [SUM_W-1:0]   w_avg_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Ready depends only on state and clr so it never loops back through in_valid.
  assign in_ready    = (r_state == ACCUM) && !clr;

  assign w_accept    = in_valid && in_ready;
  assign w_cnt_full  = (r_cnt == LAST_IDX);
  // in_last on the last slot of a full frame collapses into the same single frame end.
  assign w_frame_end = w_accept && (w_cnt_full || in_last);
  assign w_out_hs    = r_out_valid && out_ready;

  assign w_sum_nxt   = r_acc + SUM_W'(in_data);
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  // One extra bit keeps the rounding add from wrapping at the full-scale sum.
  assign w_rnd_sum   = {1'b0, w_sum_nxt} + RND_ADD;
  assign w_avg_nxt   = SUM_W'(w_rnd_sum >> AVG_SHIFT);

  assign out_valid   = r_out_valid;
  assign sum_out     = r_sum;
  assign avg_out     = r_avg;
  assign cnt_out     = r_cnt_out;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clr beats both a frame end and an output handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_frame_end) w_state_nxt = HOLD;
        HOLD:    if (w_out_hs)    w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  // Accumulator, sample counter and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_acc <= w_sum_nxt;
        r_cnt <= w_cnt_nxt;
      end
      // Accepts happen only in ACCUM and handshakes only in HOLD, so these never collide.
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Result registers keep their last values across clr; only reset zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum     <= '0;
      r_avg     <= '0;
      r_cnt_out <= '0;
    end else if (!clr && w_frame_end) begin
      r_sum     <= w_sum_nxt;
      r_avg     <= w_avg_nxt;
      r_cnt_out <= w_cnt_nxt;
    end
  end

endmodule
